// File: rtl/uart_defs.sv
// Shared UART definitions for the TX serializer and the future RX block.
//   - FSM state type (PARITY state present only with UART_TX_PARITY_EN)
//   - default CLKS_PER_BIT (12 MHz / 115200 baud)
//   - frame-length constants and helper
// Optional feature macro: UART_TX_PARITY_EN (even parity, 8E1 frames).
package uart_defs;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned DATA_BITS            = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_t;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned stop_bits);
    return 1 + DATA_BITS + PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   sync_clr in  synchronous clear of the baud counter
//   bit_tick out high for one cycle every CLKS_PER_BIT cycles, i.e. in the
//                last cycle of each bit period counted from the clear
module uart_baud_gen
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  output logic bit_tick
);

  localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sync_clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: accepts one byte per enable/ready handshake
// and shifts it out LSB first as 8N1 (or 8E1 with UART_TX_PARITY_EN).
// Ports:
//   clk             in  system clock
//   rst             in  asynchronous active-high reset
//   uart_tx_enable  in  transmit request, level-sampled in IDLE
//   uart_data_to_tx in  byte to send, captured on the accepting edge
//   uart_tx_ready   out idle and enable low (combinational)
//   uart_tx         out registered serial line, idle high
// Parameters: CLKS_PER_BIT (>= 2), STOP_BITS (1 or 2).
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_tx_enable,
  input  logic [7:0] uart_data_to_tx,
  output logic       uart_tx_ready,
  output logic       uart_tx
);

  uart_state_t state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        bit_tick;
  logic        baud_clr;

  // Holding the baud counter clear while idle aligns the first tick to
  // exactly CLKS_PER_BIT cycles after the accepting edge.
  assign baud_clr = (state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (baud_clr),
    .bit_tick (bit_tick)
  );

  assign uart_tx_ready = (state == ST_IDLE) & ~uart_tx_enable;

  // The shift register rotates rather than shifts, so its XOR always equals
  // the parity of the latched byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          if (uart_tx_enable) begin
            shift   <= uart_data_to_tx;
            bit_cnt <= '0;
            uart_tx <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            uart_tx <= shift[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift <= {shift[0], shift[7:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              uart_tx <= ^shift;
              state   <= ST_PARITY;
`else
              uart_tx <= 1'b1;
              state   <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              uart_tx <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            uart_tx <= 1'b1;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          uart_tx <= 1'b1;
          if (bit_tick) begin
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT = 4, one stop bit.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       uart_tx_enable;
  logic [7:0] uart_data_to_tx;
  logic       uart_tx_ready;
  logic       uart_tx;

  int vectors;
  int miscompares;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_tx_enable (uart_tx_enable),
    .uart_data_to_tx(uart_data_to_tx),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx        (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit period idx of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    logic p;
    p = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return p;
`endif
    return 1'b1;
  endfunction

  // Called just after the accepting edge; returns just after the edge that
  // ends the frame. pulse_at >= 0 raises enable for one cycle mid-frame.
  task automatic run_frame(input logic [7:0] b, input int pulse_at, input string tag);
    for (int i = 0; i < NB * CPB; i++) begin
      @(negedge clk);
      check($sformatf("%s_tx%0d", tag, i), {7'd0, uart_tx}, {7'd0, exp_bit(b, i / CPB)});
      check($sformatf("%s_rdy%0d", tag, i), {7'd0, uart_tx_ready}, 8'd0);
      @(posedge clk);
      #1;
      if (pulse_at >= 0) uart_tx_enable = (i == pulse_at);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_tx%0d", tag, i), {7'd0, uart_tx}, 8'd1);
      check($sformatf("%s_rdy%0d", tag, i), {7'd0, uart_tx_ready}, 8'd1);
    end
    @(posedge clk);
    #1;
  endtask

  // Request for one cycle, check combinational ready drop, then accept.
  task automatic send_one(input logic [7:0] b, input string tag);
    uart_tx_enable  = 1'b1;
    uart_data_to_tx = b;
    @(negedge clk);
    check({tag, "_rdy_comb"}, {7'd0, uart_tx_ready}, 8'd0);
    check({tag, "_tx_pre"}, {7'd0, uart_tx}, 8'd1);
    @(posedge clk);
    #1;
    uart_tx_enable  = 1'b0;
    uart_data_to_tx = ~b;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b0;
    uart_tx_enable  = 1'b0;
    uart_data_to_tx = 8'h00;

    // Reset asserted mid-clock, then 50 idle cycles.
    #3 rst = 1'b1;
    #1;
    check("rst_tx", {7'd0, uart_tx}, 8'd1);
    check("rst_rdy", {7'd0, uart_tx_ready}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(50, "idle");

    // Single byte 0x73 with an ignored second request mid-frame.
    send_one(8'h73, "b73");
    run_frame(8'h73, 19, "b73");
    idle_cycles(45, "b73_after");

    // Back-to-back 0x00 then 0xFF with enable held high.
    uart_tx_enable  = 1'b1;
    uart_data_to_tx = 8'h00;
    @(posedge clk);
    #1;
    uart_data_to_tx = 8'hFF;
    run_frame(8'h00, -1, "b2b0");
    @(negedge clk);
    check("b2b_gap_tx", {7'd0, uart_tx}, 8'd1);
    check("b2b_gap_rdy", {7'd0, uart_tx_ready}, 8'd0);
    @(posedge clk);
    #1;
    uart_tx_enable = 1'b0;
    run_frame(8'hFF, -1, "b2b1");
    idle_cycles(4, "b2b_after");

    // Reset during data bit 3 of 0xA5 (bit 3 is 0).
    send_one(8'hA5, "rstA5");
    repeat (17) @(posedge clk);
    #2;
    check("mid_tx_bit3", {7'd0, uart_tx}, 8'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {7'd0, uart_tx}, 8'd1);
    check("mid_rst_rdy", {7'd0, uart_tx_ready}, 8'd1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(8, "post_rst");
    send_one(8'hA5, "fA5");
    run_frame(8'hA5, -1, "fA5");
    idle_cycles(3, "fA5_after");

    // Even parity of 0x03 is 0 (0x73 above gives 1).
    send_one(8'h03, "b03");
    run_frame(8'h03, -1, "b03");
    idle_cycles(3, "b03_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-wide to serial UART transmitter that consumes the enable/data/ready handshake driven by the PUF readout state machine and drives the board's USB-serial TX pin. It captures one byte per accepted request and shifts it out as an 8N1 frame (optionally 8E1) at a fixed baud derived from the system clock. It reports `uart_tx_ready` low for the whole frame.

## Interface
- `CLKS_PER_BIT`, default 104: system clock cycles per bit (12 MHz / 115200 ≈ 104); legal range ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `uart_tx_enable`  in  1  transmit request, level-sampled.
- `uart_data_to_tx`  in  8  byte to send; sampled on the accepting cycle.
- `uart_tx_ready`  out  1  high when idle and able to accept.
- `uart_tx`  out  1  serial line; idle high.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- `uart_tx_ready = (state == IDLE) & ~uart_tx_enable`. This is a combinational term. It guarantees that the requester sees ready low in the same cycle its registered enable is high.
- Accept: enable is high while in IDLE at a rising edge.
  - Latch `uart_data_to_tx` into the shift register.
  - Clear the bit counter and the baud counter.
  - Go to START.
- START: drive `uart_tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive shift[0] LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7 go to PARITY (if enabled) or STOP.
- PARITY: drive the XOR of the 8 latched bits (even parity) for CLKS_PER_BIT cycles.
- STOP: drive 1 for STOP_BITS×CLKS_PER_BIT cycles, then return to IDLE.
- Enable is ignored outside IDLE. Input data changes mid-frame have no effect.
- If enable stays high continuously, frames go back-to-back. The next frame is accepted on the first IDLE cycle.
- Widths:
  - baud counter: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1.
  - bit counter: 3 bits for data; reused for stop-bit count.
- `uart_tx` is registered, so there is no glitch on the pin.

## Timing
- Reset values: state IDLE, `uart_tx` = 1, shift register 0, counters 0. `uart_tx_ready` is 1 while enable is low.
- Reset asserted mid-frame: `uart_tx` returns to 1 immediately (asynchronously) and the frame is abandoned. No partial frame resumes after reset.
- Accept edge at cycle t: `uart_tx` falls at t+1.
- Frame length: F = (1 + 8 + P + STOP_BITS)×CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- Ready returns high in cycle t+1+F, provided enable is low then.
- Minimum spacing between start-bit falling edges: F+1 cycles.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. One even-parity bit is inserted between data bit 7 and the stop bit(s), giving 8E1 frames.
- Macro undefined: the PARITY state and XOR logic are absent, giving 8N1 frames. This is the default and matches the host readout script.

## Structure
- Shared package/include `uart_defs`: state encoding localparams, default CLKS_PER_BIT, frame-length constants. The future UART RX block uses the same package.
- One sub-module, `uart_baud_gen`:
  - inputs: clk, rst, sync-clear;
  - output: one-cycle `bit_tick` every CLKS_PER_BIT cycles.
- The FSM and shift register stay in `uart_tx_serializer`.

## Test plan
- Reset idle: assert rst mid-clock, release it, hold enable = 0 for 50 cycles. Expect `uart_tx` = 1 and `uart_tx_ready` = 1 throughout.
- Single byte: CLKS_PER_BIT = 4, send 0x73. Expect line bits 0,1,1,0,0,1,1,1,0,1, each exactly 4 cycles. Expect ready low for 40 cycles and high again at t+41.
- Ready handshake: pulse enable for one cycle. Expect ready low in that same cycle (combinational). Second pulse during the frame: no extra frame is sent.
- Back-to-back: hold enable high, sending 0x00 then 0xFF. Expect two contiguous frames. Stop bit then the next start bit, no idle gap beyond 1 cycle.
- Reset mid-frame: assert rst during data bit 3. Expect `uart_tx` = 1 asynchronously, IDLE after release, and a fresh 0xA5 frame sent correctly.
- With `UART_TX_PARITY_EN`, send 0x73 and 0x03. Expect parity bits 1 and 0 respectively and 11-bit frames (44 cycles at CLKS_PER_BIT = 4).
